// File: rtl/map_phase_sched.sv
// map_phase_sched: MAP frame sequencer stepping FWD, BCK and LLR phases behind a start/done handshake.
// Outputs are registered decodes of the current state, so they trail the state register by one cycle.
module map_phase_sched #(
  parameter int AW        = 8,
  parameter int FRAME_LEN = 64,
  parameter int LLR_LAT   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] frame_len_i,
  output logic          busy_o,
  output logic [2:0]    phase_o,
  output logic [AW-1:0] step_o,
  output logic          fwd_en_o,
  output logic          alpha_we_o,
  output logic [AW-1:0] alpha_addr_o,
  output logic          bck_en_o,
  output logic          beta_init_o,
  output logic          eta_en_o,
  output logic          llr_we_o,
  output logic [AW-1:0] llr_addr_o,
  output logic          done_fwd_o,
  output logic          done_bck_o,
  output logic          done_gama_o,
  output logic          done_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FWD   = 3'd1;
  localparam logic [2:0] S_BCK   = 3'd2;
  localparam logic [2:0] S_LLR   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  typedef struct packed {
    logic          busy;
    logic [2:0]    phase;
    logic [AW-1:0] step;
    logic          fwd_en;
    logic          bck_en;
    logic          beta_init;
    logic          eta_en;
    logic          done_fwd;
    logic          done_bck;
    logic          done;
  } ctl_t;
  typedef struct packed {
    logic          last;
    logic          we;
    logic [AW-1:0] addr;
  } llr_t;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, n_q, n_d, nm1;
  logic          at_end;
  ctl_t          ctl_q, ctl_d;
  llr_t          pipe_q [LLR_LAT];
  llr_t          llr_in;
  assign nm1    = n_q - AW'(1);
  assign at_end = cnt_q == nm1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_FWD;
        cnt_d   = '0;
        n_d     = frame_len_i == '0 ? AW'(FRAME_LEN) : frame_len_i;
      end
      S_FWD: if (at_end) state_d = S_BCK; else cnt_d = cnt_q + AW'(1);
      S_BCK: if (cnt_q == '0) state_d = S_LLR; else cnt_d = cnt_q - AW'(1);
      S_LLR: begin
        state_d = at_end ? S_DRAIN : S_LLR;
        cnt_d   = at_end ? '0 : cnt_q + AW'(1);
      end
      S_DRAIN: begin
        state_d = cnt_q == AW'(LLR_LAT - 1) ? S_DONE : S_DRAIN;
        cnt_d   = cnt_q + AW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end
  // BCK is entered with cnt at N-1, so that value marks its first cycle
  always_comb begin
    ctl_d = '0;
    if (!abort_i) begin
      ctl_d.busy      = state_q != S_IDLE;
      ctl_d.phase     = state_q;
      ctl_d.step      = state_q inside {S_FWD, S_BCK, S_LLR} ? cnt_q : '0;
      ctl_d.fwd_en    = state_q == S_FWD;
      ctl_d.bck_en    = state_q == S_BCK;
      ctl_d.beta_init = state_q == S_BCK && at_end;
      ctl_d.eta_en    = state_q == S_LLR;
      ctl_d.done_fwd  = state_q == S_FWD && at_end;
      ctl_d.done_bck  = state_q == S_BCK && cnt_q == '0;
      ctl_d.done      = state_q == S_DONE;
    end
  end
  assign llr_in = {ctl_q.eta_en && ctl_q.step == nm1, ctl_q.eta_en, ctl_q.step};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      ctl_q   <= '0;
      for (int i = 0; i < LLR_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      ctl_q     <= ctl_d;
      pipe_q[0] <= abort_i ? '0 : llr_in;
      for (int i = 1; i < LLR_LAT; i++) pipe_q[i] <= abort_i ? '0 : pipe_q[i-1];
    end
  end
  assign busy_o       = ctl_q.busy;
  assign phase_o      = ctl_q.phase;
  assign step_o       = ctl_q.step;
  assign fwd_en_o     = ctl_q.fwd_en;
  assign alpha_we_o   = ctl_q.fwd_en;
  assign alpha_addr_o = ctl_q.step;
  assign bck_en_o     = ctl_q.bck_en;
  assign beta_init_o  = ctl_q.beta_init;
  assign eta_en_o     = ctl_q.eta_en;
  assign done_fwd_o   = ctl_q.done_fwd;
  assign done_bck_o   = ctl_q.done_bck;
  assign done_o       = ctl_q.done;
  assign llr_we_o     = pipe_q[LLR_LAT-1].we;
  assign llr_addr_o   = pipe_q[LLR_LAT-1].addr;
  assign done_gama_o  = pipe_q[LLR_LAT-1].last;
endmodule

// File: tb/tb_map_phase_sched.sv
// tb_map_phase_sched: randomized frames checked against a cycle-offset timeline model of the sequencer.
module tb_map_phase_sched;
  localparam int L = 3;
  logic        clk = 0, rst_n = 1, start = 0, abort = 0;
  logic [7:0]  frame_len = 0;
  logic        busy, fwd_en, alpha_we, bck_en, beta_init, eta_en, llr_we;
  logic        done_fwd, done_bck, done_gama, done;
  logic [2:0]  phase;
  logic [7:0]  step, alpha_addr, llr_addr;
  logic [37:0] obs;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  map_phase_sched #(.AW(8), .FRAME_LEN(64), .LLR_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .frame_len_i(frame_len),
    .busy_o(busy), .phase_o(phase), .step_o(step), .fwd_en_o(fwd_en), .alpha_we_o(alpha_we),
    .alpha_addr_o(alpha_addr), .bck_en_o(bck_en), .beta_init_o(beta_init), .eta_en_o(eta_en),
    .llr_we_o(llr_we), .llr_addr_o(llr_addr), .done_fwd_o(done_fwd), .done_bck_o(done_bck),
    .done_gama_o(done_gama), .done_o(done)
  );

  assign obs = {busy, phase, step, fwd_en, alpha_we, alpha_addr, bck_en, beta_init, eta_en,
                llr_we, llr_addr, done_fwd, done_bck, done_gama, done};

  // t = cycles since the edge that accepted start, n = frame length
  function automatic int stepf(int t, int n);
    return (t >= 1 && t <= n) ? t - 1 :
           (t > n && t <= 2*n) ? 2*n - t :
           (t > 2*n && t <= 3*n) ? t - 2*n - 1 : 0;
  endfunction

  function automatic logic [37:0] model(int t, int n);
    int         a   = 3*n + L;
    logic       fwd = t >= 1 && t <= n;
    logic       bck = t > n && t <= 2*n;
    logic       eta = t > 2*n && t <= 3*n;
    logic       we  = t > 2*n + L && t <= a;
    logic [2:0] ph  = (t < 1 || t > a + 1) ? 3'd0 : fwd ? 3'd1 : bck ? 3'd2 : eta ? 3'd3 :
                      t <= a ? 3'd4 : 3'd5;
    logic [7:0] st  = 8'(stepf(t, n));
    logic [7:0] la  = 8'(stepf(t - L, n));
    return {t >= 1 && t <= a + 1, ph, st, fwd, fwd, st, bck, t == n + 1, eta, we, la,
            t == n, t == 2*n, t == a, t == a + 1};
  endfunction

  task automatic test_reset();
    #3 rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h want=0", obs);
    end
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("FAIL reset_release got=%h want=0", obs);
      end
    end
  endtask

  task automatic test_idle_start_abort();
    start = 1;
    abort = 1;
    frame_len = 8'd5;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("FAIL idle_start_abort got=%h want=0", obs);
      end
    end
    start = 0;
    abort = 0;
  endtask

  // back-to-back frames with random start pulses and frame_len churn while busy
  task automatic test_frames();
    int lens[9] = '{4, 0, 1, 8, 0, 0, 0, 0, 0};
    for (int i = 4; i < 8; i++) lens[i] = $urandom_range(1, 20);
    @(negedge clk);
    start = 1;
    frame_len = 8'(lens[0]);
    for (int f = 0; f < 8; f++) begin
      int n    = lens[f] == 0 ? 64 : lens[f];
      int last = 3*n + L + 1;
      for (int t = 0; t <= last; t++) begin
        @(negedge clk);
        checks++;
        if (obs !== model(t, n)) begin
          failures++;
          $display("FAIL frame%0d n=%0d t=%0d got=%h want=%h", f, n, t, obs, model(t, n));
        end
        if (t == last) begin
          start = f < 7;
          frame_len = 8'(lens[f+1]);
        end else begin
          start = $urandom_range(0, 3) == 0;
          frame_len = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL frames_idle got=%h want=0", obs);
    end
  endtask

  // abort sampled at edge 12 (BCK), restart accepted at edge 14
  task automatic test_abort();
    @(negedge clk);
    start = 1;
    frame_len = 8'd8;
    for (int t = 0; t <= 42; t++) begin
      @(negedge clk);
      if (t != 12) begin
        checks++;
        if (obs !== (t < 12 ? model(t, 8) : model(t - 14, 8))) begin
          failures++;
          $display("FAIL abort t=%0d got=%h want=%h", t, obs,
                   t < 12 ? model(t, 8) : model(t - 14, 8));
        end
      end
      abort = t == 11;
      start = t == 13;
      frame_len = t == 13 ? 8'd8 : 8'($urandom);
    end
    start = 0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1;
    frame_len = 8'd8;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      start = 0;
    end
    checks++;
    if (obs !== model(20, 8)) begin
      failures++;
      $display("FAIL pre_reset got=%h want=%h", obs, model(20, 8));
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", obs);
    end
    @(negedge clk);
    rst_n = 1;
    start = 1;
    frame_len = 8'd1;
    for (int t = 0; t <= 3 + L + 2; t++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (obs !== model(t, 1)) begin
        failures++;
        $display("FAIL after_reset n=1 t=%0d got=%h want=%h", t, obs, model(t, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_start_abort();
    test_frames();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
